// File: rtl/seq_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_logic_unit
// Function : Handshaked multi-cycle bitwise logic unit. Each BUSY cycle
//            computes SLICE result bits. The optional popcount output is
//            enabled with the macro SEQ_LOGIC_POPCNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               op_err
`ifdef SEQ_LOGIC_POPCNT_EN
  ,
  output logic [$clog2(WIDTH):0] popcnt
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
      $error("seq_logic_unit: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_y;
  logic               r_op_err;
  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_b_sl;
  logic [SLICE-1:0]   w_slice;
  logic               w_accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: begin
        if (r_cnt == C_LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = in_ready && in_valid;

  // Constant-index mux keeps the slice select free of variable part-selects.
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(r_cnt) == i) begin
        w_a_sl = r_a[i*SLICE +: SLICE];
        w_b_sl = r_b[i*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    w_slice = '0;
    case (r_op)
      3'd0:    w_slice = w_a_sl & w_b_sl;
      3'd1:    w_slice = w_a_sl | w_b_sl;
      3'd2:    w_slice = ~w_a_sl;
      3'd3:    w_slice = ~(w_a_sl & w_b_sl);
      3'd4:    w_slice = ~(w_a_sl | w_b_sl);
      3'd5:    w_slice = w_a_sl ^ w_b_sl;
      3'd6:    w_slice = ~(w_a_sl ^ w_b_sl);
      default: w_slice = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_op_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= op;
      r_a      <= a;
      r_b      <= b;
      r_y      <= '0;
      r_op_err <= (op == 3'd7);
    end else if (r_state == BUSY) begin
      for (int i = 0; i < N; i++) begin
        if (int'(r_cnt) == i) r_y[i*SLICE +: SLICE] <= w_slice;
      end
      // The counter saturates at the last slice; only a new accept clears it.
      if (r_cnt != C_LAST) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SEQ_LOGIC_POPCNT_EN
  logic [$clog2(WIDTH):0] r_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pop <= '0;
    end else if (w_accept) begin
      r_pop <= '0;
    end else if (r_state == BUSY) begin
      r_pop <= r_pop + ($clog2(WIDTH)+1)'($countones(w_slice));
    end
  end

  assign popcnt = r_pop;
`endif

  assign y      = r_y;
  assign op_err = r_op_err;
  assign zero   = out_valid && (r_y == '0);

endmodule
`default_nettype wire

// File: tb/tb_seq_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_logic_unit
// Function : Scoreboard bench for seq_logic_unit (WIDTH=32, SLICE=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_logic_unit;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  y;
  logic              zero;
  logic              op_err;
`ifdef SEQ_LOGIC_POPCNT_EN
  logic [5:0]        popcnt;
`endif

  seq_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .op_err    (op_err)
`ifdef SEQ_LOGIC_POPCNT_EN
    ,
    .popcnt    (popcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic        err;
    logic [5:0]  pc;
  } exp_t;

  exp_t sb[$];
  int   lat_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~x;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return 32'h0;
    endcase
  endfunction

  // Drive one request, push its expectation at the accept edge, then scramble inputs.
  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    exp_t e;
    int   k;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = z;
    k  = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.y    = model(o, x, z);
    e.zero = (e.y == 32'h0);
    e.err  = (o == 3'd7);
    e.pc   = 6'($countones(e.y));
    sb.push_back(e);
    lat_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_val("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check_val("idle_in_ready", 64'(in_ready), 64'd1);
    check_val("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   acc;
    if (!resetn) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          check_val("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          acc = lat_q.pop_front();
          check_val("latency", 64'(cyc - acc), 64'(N));
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("y", 64'(y), 64'(e.y));
          check_val("zero", 64'(zero), 64'(e.zero));
          check_val("op_err", 64'(op_err), 64'(e.err));
`ifdef SEQ_LOGIC_POPCNT_EN
          check_val("popcnt", 64'(popcnt), 64'(e.pc));
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    int k;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_y", 64'(y), 64'd0);
    check_val("rst_zero", 64'(zero), 64'd0);
    check_val("rst_op_err", 64'(op_err), 64'd0);
`ifdef SEQ_LOGIC_POPCNT_EN
    check_val("rst_popcnt", 64'(popcnt), 64'd0);
`endif
    resetn = 1'b1;

    // Basic AND with one-cycle DONE
    send(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    drain();

    // Back-to-back requests
    send(3'd6, 32'h1234_5678, 32'h1234_5678);
    send(3'd5, 32'h1234_5678, 32'h1234_5678);
    send(3'd2, 32'h1234_5678, $urandom);
    drain();

    // Backpressure with a competing request held on the input
    out_ready = 1'b0;
    send(3'd4, 32'h0, 32'h0);
    in_valid = 1'b1;
    op = 3'd1;
    a  = 32'h0F0F_0000;
    b  = 32'h0000_00F0;
    k  = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_y", 64'(y), 64'hFFFF_FFFF);
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      check_val("bp_out_valid_hold", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd1, 32'h0F0F_0000, 32'h0000_00F0);
    drain();

    // Reserved op then a normal op clears the error flag
    send(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(3'd1, 32'h0000_0001, 32'h0000_0002);
    drain();

    // Asynchronous reset during the second BUSY cycle
    send(3'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    in_valid = 1'b1;
    op = 3'd0;
    a  = 32'hFFFF_FFFF;
    b  = 32'hFFFF_FFFF;
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_y", 64'(y), 64'd0);
    check_val("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("post_rst_y", 64'(y), 64'd0);
    send(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Popcount stimulus (same y expected when the feature is absent)
    send(3'd1, 32'h0000_00FF, 32'h0F00_0000);
    drain();

    for (int i = 0; i < 10; i++) begin
      send(3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
- Sequential, handshaked bitwise-logic execution unit for the MIPS datapath.
- Drives operands into a slice-wise logic datapath covering AND, OR, NOT, NAND, NOR, XOR and XNOR.
- Accepts one request (op, a, b) on a valid/ready input channel.
- Computes the result SLICE bits per clock and returns it on a valid/ready output channel with a zero flag.
- Serves as the multi-cycle logic slot of the ALU/issue path.

Parameters:
WIDTH, 32, operand/result width in bits
SLICE, 8, bits computed per BUSY cycle; WIDTH must be a multiple of SLICE (elaboration error otherwise); N = WIDTH/SLICE

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept request
op  input  3  0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved
a  input  WIDTH  operand a
b  input  WIDTH  operand b (ignored for op 2)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  WIDTH  result register
zero  output  1  out_valid and (y == 0)
op_err  output  1  result came from reserved op 7

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on resetn. All state registers use async clear.
- Reset values:
  - State IDLE, slice counter 0, y = 0, out_valid = 0, op_err = 0, zero = 0.
  - in_ready = 1, since in_ready = (state == IDLE) is decoded from state.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch op, a, b into internal registers; clear y and the counter; set op_err = (op == 7); go to BUSY.
- FSM BUSY:
  - in_ready = 0, out_valid = 0.
  - Each clock, write y[cnt*SLICE +: SLICE] with the latched op applied to the same slice of a and b.
  - Increment cnt. When cnt == N-1, go to DONE on the same edge.
- FSM DONE:
  - out_valid = 1; y, zero and op_err are held stable.
  - On out_ready, go to IDLE. The next request can be accepted no earlier than the following cycle.
- Latency: out_valid is first high exactly N cycles after the accept edge. SLICE == WIDTH gives N = 1.
- Throughput: one request per N+2 cycles, best case.
- Op 7: every slice writes 0, giving y = 0, op_err = 1, zero = 1.
- Backpressure: out_ready low in DONE holds all outputs indefinitely. in_valid is ignored (in_ready = 0) in BUSY and DONE. Input operands may change after the accept edge without affecting the result.
- Reset mid-operation: the transaction is dropped with no output. All registers return to reset values immediately (asynchronous). in_valid is ignored while resetn = 0.
- The counter width is clog2(N), minimum 1. It never exceeds N-1 and wraps to 0 only by re-accept.

Optional Feature:
- Macro SEQ_LOGIC_POPCNT_EN.
- When defined:
  - Adds output port popcnt, width clog2(WIDTH)+1.
  - popcnt is cleared on accept and accumulates the count of 1-bits in each slice as it is written.
  - It is valid and stable in DONE, with reset value 0.
  - For op 7, popcnt = 0.
- When undefined: the port and its accumulator are absent, and all other behaviour is identical.

Test Plan (WIDTH=32, SLICE=8):
1. op 0, a=F0F0_F0F0, b=FF00_FF00, out_ready=1 -> out_valid high exactly 4 cycles after accept, y=F000_F000, zero=0, op_err=0, one-cycle DONE, then IDLE with in_ready=1.
2. Back-to-back ops with a=b=1234_5678:
   - op 6 -> y=FFFF_FFFF, zero=0.
   - op 5 -> y=0000_0000, zero=1.
   - op 2 with b=X -> y=EDCB_A987.
3. Backpressure: op 4, a=0, b=0, out_ready low for 10 cycles -> y=FFFF_FFFF stable throughout, in_ready=0, a concurrent in_valid request is not accepted. The request is accepted only after out_ready drops the unit to IDLE.
4. Reserved op 7, a=FFFF_FFFF, b=FFFF_FFFF -> y=0, op_err=1, zero=1. A following op 1 clears op_err to 0.
5. resetn asserted in the 2nd BUSY cycle of op 3 -> out_valid=0, y=0, in_ready=1 immediately. After release, a new op 0 request with a=b=FFFF_FFFF completes with y=FFFF_FFFF.
6. (SEQ_LOGIC_POPCNT_EN) op 1, a=0000_00FF, b=0F00_0000 -> y=0F00_00FF, popcnt=12. With the macro undefined, the same stimulus gives the same y and the port is absent.
